// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the pipelined ALU.
//   ALU_LENGTH      : width of the opcode field
//   ALU_*           : opcode encodings, base integer ops followed by the M ops
//   alu_state_t     : control FSM state encoding (IDLE, BUSY, DONE)
//   is_muldiv_op()  : true for the multiply/divide opcodes
package alu_pkg;

   localparam int ALU_LENGTH = 5;

   localparam logic [ALU_LENGTH-1:0] ALU_ADD    = 5'd0;
   localparam logic [ALU_LENGTH-1:0] ALU_SUB    = 5'd1;
   localparam logic [ALU_LENGTH-1:0] ALU_AND    = 5'd2;
   localparam logic [ALU_LENGTH-1:0] ALU_OR     = 5'd3;
   localparam logic [ALU_LENGTH-1:0] ALU_XOR    = 5'd4;
   localparam logic [ALU_LENGTH-1:0] ALU_SLL    = 5'd5;
   localparam logic [ALU_LENGTH-1:0] ALU_SRL    = 5'd6;
   localparam logic [ALU_LENGTH-1:0] ALU_SRA    = 5'd7;
   localparam logic [ALU_LENGTH-1:0] ALU_SLT    = 5'd8;
   localparam logic [ALU_LENGTH-1:0] ALU_SLTU   = 5'd9;
   localparam logic [ALU_LENGTH-1:0] ALU_EQ     = 5'd10;
   localparam logic [ALU_LENGTH-1:0] ALU_MUL    = 5'd11;
   localparam logic [ALU_LENGTH-1:0] ALU_MULH   = 5'd12;
   localparam logic [ALU_LENGTH-1:0] ALU_MULHSU = 5'd13;
   localparam logic [ALU_LENGTH-1:0] ALU_MULHU  = 5'd14;
   localparam logic [ALU_LENGTH-1:0] ALU_DIV    = 5'd15;
   localparam logic [ALU_LENGTH-1:0] ALU_DIVU   = 5'd16;
   localparam logic [ALU_LENGTH-1:0] ALU_REM    = 5'd17;
   localparam logic [ALU_LENGTH-1:0] ALU_REMU   = 5'd18;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } alu_state_t;

   function automatic logic is_muldiv_op(input logic [ALU_LENGTH-1:0] op);
      logic hit;
      case (op)
         ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
         ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: hit = 1'b1;
         default:                              hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/alu_pipe_muldiv.sv
// alu_muldiv_iter -- iterative multiply/divide core, one bit per cycle.
// Shift-add multiply and restoring divide on operand magnitudes; the sign
// fix-up is folded into the final-iteration result so no extra cycle is spent.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   start          : load operands and begin (only pulsed while idle)
//   op             : M opcode from alu_pkg, sampled with start
//   left, right    : operands, sampled with start
//   done           : high during the last of XLEN iterations
//   result         : final value, valid while done is high (combinational)
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ALU_LENGTH-1:0] op,
   input  logic [XLEN-1:0]       left,
   input  logic [XLEN-1:0]       right,
   output logic                  done,
   output logic [XLEN-1:0]       result
);

   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0]     LAST_ITER = CW'(XLEN - 1);
   localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
   localparam logic [XLEN-1:0]   ONE_X     = XLEN'(1);
   localparam logic [2*XLEN-1:0] ONE_2X    = (2*XLEN)'(1);

   logic                  busy_r;
   logic [CW-1:0]         count_r;
   logic [ALU_LENGTH-1:0] op_r;
   // multiply: {accumulator_hi, multiplier}; divide: {remainder, quotient/dividend}
   logic [2*XLEN-1:0]     work_r;
   logic [XLEN-1:0]       opnd_r;
   logic                  neg_main_r;
   logic                  neg_rem_r;
   logic                  div_zero_r;

   logic                  is_div_s;
   logic                  left_neg_s;
   logic                  right_neg_s;
   logic [XLEN-1:0]       left_mag_s;
   logic [XLEN-1:0]       right_mag_s;
   logic                  div_op_r_s;
   logic [XLEN:0]         mul_sum_s;
   logic [XLEN:0]         rem_shift_s;
   logic [XLEN:0]         diff_s;
   logic [2*XLEN-1:0]     next_work_s;
   logic [2*XLEN-1:0]     prod_s;
   logic [XLEN-1:0]       quot_s;
   logic [XLEN-1:0]       rem_s;

   // Decode the incoming request: signedness and operand magnitudes.
   always_comb begin
      is_div_s    = (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
      left_neg_s  = ((op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_DIV) || (op == ALU_REM))
                    && left[XLEN-1];
      right_neg_s = ((op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM)) && right[XLEN-1];
      left_mag_s  = left_neg_s  ? (~left  + ONE_X) : left;
      right_mag_s = right_neg_s ? (~right + ONE_X) : right;
   end

   // One iteration of shift-add multiply or restoring divide.
   always_comb begin
      div_op_r_s  = (op_r == ALU_DIV) || (op_r == ALU_DIVU) || (op_r == ALU_REM) || (op_r == ALU_REMU);
      mul_sum_s   = {1'b0, work_r[2*XLEN-1:XLEN]} + (work_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
      rem_shift_s = {work_r[2*XLEN-1:XLEN], work_r[XLEN-1]};
      diff_s      = rem_shift_s - {1'b0, opnd_r};
      if (div_op_r_s) begin
         // diff sign bit clear means the divisor fits: keep the difference, quotient bit 1
         if (!diff_s[XLEN]) begin
            next_work_s = {diff_s[XLEN-1:0], work_r[XLEN-2:0], 1'b1};
         end else begin
            next_work_s = {rem_shift_s[XLEN-1:0], work_r[XLEN-2:0], 1'b0};
         end
      end else begin
         next_work_s = {mul_sum_s, work_r[XLEN-1:1]};
      end
   end

   // Final result with sign fix-up, taken from the last iteration's output.
   always_comb begin
      prod_s = neg_main_r ? (~next_work_s + ONE_2X) : next_work_s;
      quot_s = next_work_s[XLEN-1:0];
      rem_s  = next_work_s[2*XLEN-1:XLEN];
      case (op_r)
         ALU_MUL:                          result = prod_s[XLEN-1:0];
         ALU_MULH, ALU_MULHSU, ALU_MULHU:  result = prod_s[2*XLEN-1:XLEN];
         // magnitude quotient is already all ones for a zero divisor; only the
         // signed form must skip negation
         ALU_DIV:  result = div_zero_r ? {XLEN{1'b1}} : (neg_main_r ? (~quot_s + ONE_X) : quot_s);
         ALU_DIVU: result = quot_s;
         ALU_REM:  result = neg_rem_r ? (~rem_s + ONE_X) : rem_s;
         ALU_REMU: result = rem_s;
         default:  result = {XLEN{1'b0}};
      endcase
      done = busy_r && (count_r == LAST_ITER);
   end

   // Iteration state: load on start, step each busy cycle, idle after last step.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_r     <= 1'b0;
         count_r    <= {CW{1'b0}};
         op_r       <= {ALU_LENGTH{1'b0}};
         work_r     <= {(2*XLEN){1'b0}};
         opnd_r     <= {XLEN{1'b0}};
         neg_main_r <= 1'b0;
         neg_rem_r  <= 1'b0;
         div_zero_r <= 1'b0;
      end else if (start) begin
         busy_r     <= 1'b1;
         count_r    <= {CW{1'b0}};
         op_r       <= op;
         work_r     <= {{XLEN{1'b0}}, (is_div_s ? left_mag_s : right_mag_s)};
         opnd_r     <= is_div_s ? right_mag_s : left_mag_s;
         neg_main_r <= left_neg_s ^ right_neg_s;
         neg_rem_r  <= left_neg_s;
         div_zero_r <= (right == {XLEN{1'b0}});
      end else if (busy_r) begin
         work_r <= next_work_s;
         if (done) begin
            busy_r  <= 1'b0;
            count_r <= {CW{1'b0}};
         end else begin
            count_r <= count_r + CNT_ONE;
         end
      end else begin
         busy_r <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe -- ALU with valid/ready handshake and an IDLE/BUSY/DONE controller.
// Single-cycle ops produce a result the cycle after acceptance; with the
// ALU_MULDIV_EN macro defined, M ops run on the iterative alu_muldiv_iter core
// for XLEN cycles. Without the macro M opcodes behave like unknown opcodes.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in_valid / in_ready  : request handshake (ready only in IDLE)
//   opcode, left, right  : operation and operands, captured on acceptance
//   out_valid / out_ready: result handshake
//   result               : registered result, held until consumed
module alu_pipe
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ALU_LENGTH-1:0] opcode,
   input  logic [XLEN-1:0]       left,
   input  logic [XLEN-1:0]       right,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       result
);

   localparam int SHW = $clog2(XLEN);

   alu_state_t      state_r;
   logic            in_ready_r;
   logic            out_valid_r;
   logic [XLEN-1:0] result_r;

   logic [SHW-1:0]  shamt_s;
   logic [XLEN-1:0] alu_s;

`ifdef ALU_MULDIV_EN
   logic            md_start_s;
   logic            md_done_s;
   logic [XLEN-1:0] md_result_s;

   assign md_start_s = (state_r == ST_IDLE) && in_valid && is_muldiv_op(opcode);

   alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
      .clk    (clk),
      .reset  (reset),
      .start  (md_start_s),
      .op     (opcode),
      .left   (left),
      .right  (right),
      .done   (md_done_s),
      .result (md_result_s)
   );
`endif

   // Single-cycle datapath computed straight from the request inputs.
   always_comb begin
      shamt_s = right[SHW-1:0];
      case (opcode)
         ALU_ADD:  alu_s = left + right;
         ALU_SUB:  alu_s = left - right;
         ALU_AND:  alu_s = left & right;
         ALU_OR:   alu_s = left | right;
         ALU_XOR:  alu_s = left ^ right;
         ALU_SLL:  alu_s = left << shamt_s;
         ALU_SRL:  alu_s = left >> shamt_s;
         ALU_SRA:  alu_s = $signed(left) >>> shamt_s;
         ALU_SLT:  alu_s = {{(XLEN-1){1'b0}}, ($signed(left) < $signed(right))};
         ALU_SLTU: alu_s = {{(XLEN-1){1'b0}}, (left < right)};
         ALU_EQ:   alu_s = {{(XLEN-1){1'b0}}, (left == right)};
         default:  alu_s = {XLEN{1'b0}};
      endcase
   end

   // Control FSM with registered handshake outputs and result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         result_r    <= {XLEN{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  in_ready_r <= 1'b0;
`ifdef ALU_MULDIV_EN
                  if (is_muldiv_op(opcode)) begin
                     state_r <= ST_BUSY;
                  end else begin
                     state_r     <= ST_DONE;
                     out_valid_r <= 1'b1;
                     result_r    <= alu_s;
                  end
`else
                  state_r     <= ST_DONE;
                  out_valid_r <= 1'b1;
                  result_r    <= alu_s;
`endif
               end else begin
                  in_ready_r <= 1'b1;
               end
            end
            ST_BUSY: begin
`ifdef ALU_MULDIV_EN
               if (md_done_s) begin
                  state_r     <= ST_DONE;
                  out_valid_r <= 1'b1;
                  result_r    <= md_result_s;
               end else begin
                  state_r <= ST_BUSY;
               end
`else
               // no iterative core in this build; recover to IDLE
               state_r    <= ST_IDLE;
               in_ready_r <= 1'b1;
`endif
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_r     <= ST_IDLE;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
               end else begin
                  state_r <= ST_DONE;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
               result_r    <= {XLEN{1'b0}};
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign result    = result_r;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe -- self-checking bench for alu_pipe (XLEN=32).
// Directed corner cases plus randomized operations checked against an
// arithmetic reference model; covers latency, backpressure and reset.
module tb_alu_pipe;
   import alu_pkg::*;

   localparam int XLEN = 32;
`ifdef ALU_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  in_valid;
   logic                  in_ready;
   logic [ALU_LENGTH-1:0] opcode;
   logic [XLEN-1:0]       left;
   logic [XLEN-1:0]       right;
   logic                  out_valid;
   logic                  out_ready;
   logic [XLEN-1:0]       result;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_pipe #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .left      (left),
      .right     (right),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit is_m(input logic [ALU_LENGTH-1:0] op);
      return (op >= ALU_MUL) && (op <= ALU_REMU);
   endfunction

   function automatic int ref_latency(input logic [ALU_LENGTH-1:0] op);
      return (MD && is_m(op)) ? XLEN + 1 : 1;
   endfunction

   // Reference model: plain 64-bit arithmetic on the architectural rules.
   function automatic logic [31:0] ref_result(input logic [ALU_LENGTH-1:0] op,
                                              input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, p;
      logic [63:0]        up;
      logic signed [31:0] s32;
      logic [31:0]        r;
      bit                 ovf;
      sa  = $signed({{32{a[31]}}, a});
      sb  = $signed({{32{b[31]}}, b});
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      if (!MD && is_m(op)) return 32'h0;
      case (op)
         ALU_ADD:  r = a + b;
         ALU_SUB:  r = a - b;
         ALU_AND:  r = a & b;
         ALU_OR:   r = a | b;
         ALU_XOR:  r = a ^ b;
         ALU_SLL:  r = a << b[4:0];
         ALU_SRL:  r = a >> b[4:0];
         ALU_SRA:  begin s32 = $signed(a); r = s32 >>> b[4:0]; end
         ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
         ALU_EQ:   r = (a == b) ? 32'd1 : 32'd0;
         ALU_MUL:  begin up = {32'h0, a} * {32'h0, b}; r = up[31:0]; end
         ALU_MULH: begin p = sa * sb; r = p[63:32]; end
         ALU_MULHSU: begin p = sa * $signed({32'h0, b}); r = p[63:32]; end
         ALU_MULHU: begin up = {32'h0, a} * {32'h0, b}; r = up[63:32]; end
         ALU_DIV:  r = (b == 32'h0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
         ALU_DIVU: r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
         ALU_REM:  r = (b == 32'h0) ? a : (ovf ? 32'h0 : 32'($signed(a) % $signed(b)));
         ALU_REMU: r = (b == 32'h0) ? a : a % b;
         default:  r = 32'h0;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 6))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   // Issue one request and follow it through to consumption.
   task automatic run_op(input string tag, input logic [ALU_LENGTH-1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat, input int hold);
      int lat;
      @(negedge clk);
      lat = 0;
      while (!in_ready && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      in_valid  = 1'b1;
      opcode    = op;
      left      = a;
      right     = b;
      out_ready = (hold == 0);
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!out_valid) begin
            // junk that must be ignored while not IDLE
            in_valid = 1'($urandom_range(0, 1));
            opcode   = ALU_LENGTH'($urandom);
            left     = 32'($urandom);
            right    = 32'($urandom);
         end
      end while (!out_valid && lat < 200);
      check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check_eq({tag, "_result"}, 64'(result), 64'(exp));
      check_eq({tag, "_busy_ready"}, 64'(in_ready), 64'd0);
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'($urandom_range(0, 1));
         opcode   = ALU_LENGTH'($urandom);
         @(negedge clk);
         check_eq({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
         check_eq({tag, "_hold_result"}, 64'(result), 64'(exp));
         check_eq({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check_eq({tag, "_drain_valid"}, 64'(out_valid), 64'd0);
      check_eq({tag, "_drain_ready"}, 64'(in_ready), 64'd1);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [ALU_LENGTH-1:0] rop;
      logic [31:0]           ra;
      logic [31:0]           rb;
      bit                    stale;

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      opcode    = '0;
      left      = 32'h0;
      right     = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_in_ready", 64'(in_ready), 64'd1);
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_result", 64'(result), 64'd0);
      reset = 1'b0;

      run_op("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1, 0);
      run_op("sra_big", ALU_SRA, 32'h8000_0000, 32'h21, 32'hC000_0000, 1, 0);
      run_op("mulh_m1", ALU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, MD ? 33 : 1, 0);
      run_op("mulhu_max", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             MD ? 32'hFFFF_FFFE : 32'h0, MD ? 33 : 1, 0);
      run_op("div_by0", ALU_DIV, 32'd7, 32'd0, MD ? 32'hFFFF_FFFF : 32'h0, MD ? 33 : 1, 0);
      run_op("rem_by0", ALU_REM, 32'd7, 32'd0, MD ? 32'd7 : 32'h0, MD ? 33 : 1, 0);
      run_op("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
             MD ? 32'h8000_0000 : 32'h0, MD ? 33 : 1, 0);
      run_op("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, MD ? 33 : 1, 0);
      run_op("mul_3x4", ALU_MUL, 32'd3, 32'd4, MD ? 32'd12 : 32'h0, MD ? 33 : 1, 2);
      run_op("add_bp", ALU_ADD, 32'd5, 32'd6, 32'd11, 1, 5);
      run_op("slt_neg", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 0);
      run_op("sltu_neg", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0);
      run_op("unknown", 5'd31, 32'd9, 32'd9, 32'h0, 1, 1);

      // reset in the middle of a DIVU
      @(negedge clk);
      in_valid = 1'b1;
      opcode   = ALU_DIVU;
      left     = 32'd100;
      right    = 32'd7;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
      check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
      check_eq("midrst_result", 64'(result), 64'd0);
      stale = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (out_valid) stale = 1'b1;
      end
      check_eq("midrst_no_stale", 64'(stale), 64'd0);
      run_op("after_rst", ALU_SUB, 32'd10, 32'd3, 32'd7, 1, 0);

      for (int i = 0; i < 150; i++) begin
         rop = ALU_LENGTH'($urandom_range(0, 20));
         ra  = pick_operand();
         rb  = pick_operand();
         run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb,
                ref_result(rop, ra, rb), ref_latency(rop), $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001: Parameter XLEN, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: reset  input  1  reset, synchronous and active-high.
REQ-004: in_valid  input  1  operation request valid.
REQ-005: in_ready  output  1  block accepts a request this cycle.
REQ-006: opcode  input  ALU_LENGTH  operation select, encodings from shared package.
REQ-007: left, right  input  XLEN each  operands.
REQ-008: out_valid  output  1  result valid.
REQ-009: out_ready  input  1  consumer accepts result.
REQ-010: result  output  XLEN  registered result, stable while out_valid=1 and out_ready=0.

Function
REQ-011: FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE.
REQ-012: IDLE and in_valid=1: operands and opcode captured; single-cycle op -> DONE, M op -> BUSY.
REQ-013: Single-cycle ops (ADD, AND, OR, SUB, XOR, SLL, SLT, SLTU, SRL, SRA, EQ): accepted cycle N -> out_valid=1 at N+1.
REQ-014: Shifts use right[log2(XLEN)-1:0] only; upper bits of right ignored.
REQ-015: SLT/SLTU/EQ yield 0 or 1 zero-extended to XLEN.
REQ-016: M ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU): BUSY exactly XLEN cycles, one bit per cycle (shift-add multiply, restoring divide); accepted cycle N -> out_valid=1 at N+XLEN+1.
REQ-017: Signed M ops iterate on magnitudes; sign fix-up applied when leaving BUSY, no extra cycle.
REQ-018: MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits of the 2*XLEN product with RISC-V signedness.
REQ-019: Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = left; latency unchanged.
REQ-020: DIV overflow (left = -2^(XLEN-1), right = -1): quotient = left, remainder = 0.
REQ-021: DONE: out_valid=1 until cycle where out_ready=1, then IDLE next cycle; no new request accepted in DONE.
REQ-022: Unknown opcode: single-cycle, result = 0.
REQ-023: Inputs other than out_ready ignored outside IDLE; in_valid dropping during BUSY has no effect.

Reset
REQ-024: reset=1 at clock edge -> IDLE, in_ready=1, out_valid=0, result=0, iteration counter=0, regardless of state.
REQ-025: Reset mid-BUSY or mid-DONE discards the operation; no out_valid pulse follows.

Configuration
REQ-026: Macro ALU_MULDIV_EN: defined -> M ops per REQ-016..020.
REQ-027: Undefined -> no iterative datapath, BUSY never entered, M opcodes treated as unknown (REQ-022).

Structure
REQ-028: Shared package alu_pkg holds ALU_LENGTH, all ALU_* opcode constants incl. M ops, FSM state encoding.
REQ-029: Iterative mul/div core is sub-module alu_muldiv_iter (start, op, operands in; done, result out), instantiated only under ALU_MULDIV_EN.

Verification (XLEN=32)
REQ-030: ADD 0x7FFFFFFF+1, out_ready=1 -> out_valid cycle N+1, result 0x80000000; SRA 0x80000000 by right=0x00000021 -> 0xC0000000.
REQ-031: MULH -1 * -1 -> result 0 at N+33; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-032: DIV 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
REQ-033: Backpressure: out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-034: reset at BUSY cycle 10 of DIVU -> next cycle in_ready=1, out_valid=0, result=0; no stale result later.
REQ-035: Build without ALU_MULDIV_EN: MUL 3*4 -> out_valid at N+1, result 0.
